// File: rtl/mac_rx_frame_sequencer_if.sv
// Signal bundle of the RX frame sequencer. It carries the incoming RX word stream, the
// frame-buffer write port, the checker handshake and the abort/drop status.
// The sequencer connects through the master modport and its environment through the slave modport.
interface mac_rx_frame_sequencer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 11
);
    logic [DATA_WIDTH-1:0] i_rx_data;
    logic [CTRL_WIDTH-1:0] i_rx_ctrl;
    logic                  i_rx_valid;
    logic                  o_wr_en;
    logic [ADDR_WIDTH-1:0] o_wr_addr;
    logic [DATA_WIDTH-1:0] o_wr_data;
    logic                  o_frame_valid;
    logic [LEN_WIDTH-1:0]  o_frame_len;
    logic                  i_check_ready;
    logic                  o_abort;
    logic [15:0]           o_drop_cnt;
    logic [15:0]           o_abort_cnt;

    modport master (
        input  i_rx_data, i_rx_ctrl, i_rx_valid, i_check_ready,
        output o_wr_en, o_wr_addr, o_wr_data, o_frame_valid, o_frame_len,
               o_abort, o_drop_cnt, o_abort_cnt
    );

    modport slave (
        output i_rx_data, i_rx_ctrl, i_rx_valid, i_check_ready,
        input  o_wr_en, o_wr_addr, o_wr_data, o_frame_valid, o_frame_len,
               o_abort, o_drop_cnt, o_abort_cnt
    );
endinterface

// File: rtl/mac_rx_frame_sequencer.sv
// RX MAC frame sequencer. It finds START/TERM framing in the 64b/8b word stream and
// writes each frame into an external buffer. It then offers the buffered frame to the
// checker, and it drops or aborts frames that cannot be accepted.
module mac_rx_frame_sequencer #(
    parameter int         DATA_WIDTH     = 64,
    parameter int         CTRL_WIDTH     = 8,
    parameter int         MAX_FRAME_SIZE = 1518,
    parameter int         ADDR_WIDTH     = 8,
    parameter int         LEN_WIDTH      = 11,
    parameter logic [7:0] START_CODE     = 8'hFB,
    parameter logic [7:0] TERM_CODE      = 8'hFD
) (
    input logic clk,
    input logic i_rst,
    mac_rx_frame_sequencer_if.master bus
);
    // One spare bit so that byte_cnt+8 and byte_cnt+lane never wrap before the size compare.
    localparam int                 CNT_W   = LEN_WIDTH + 1;
    localparam logic [CNT_W-1:0]   MAX_LEN = CNT_W'(MAX_FRAME_SIZE);
    localparam logic [CNT_W-1:0]   WORD_B  = CNT_W'(CTRL_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

    state_t           state;
    logic [CNT_W-1:0] byte_cnt;   // bytes of the open frame already written
    logic             is_start;
    logic             term_found;
    int               term_idx;
    logic             ctrl_err;
    logic [CNT_W-1:0] term_len;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Classify the current word: START in lane 0, lowest TERM lane, stray control characters.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
        is_start   = bus.i_rx_valid && bus.i_rx_ctrl[0] && (bus.i_rx_data[7:0] == START_CODE);
        term_found = 1'b0;
        term_idx   = 0;
        ctrl_err   = 1'b0;
        // Scanning downwards leaves the lowest TERM lane in term_idx.
        for (int j = CTRL_WIDTH - 1; j >= 0; j--) begin
            if (bus.i_rx_ctrl[j] && (bus.i_rx_data[8*j +: 8] == TERM_CODE)) begin
                term_found = 1'b1;
                term_idx   = j;
            end
        end
        // Control characters after TERM are idles and are legal. Any control character before TERM is an error.
        for (int j = 0; j < CTRL_WIDTH; j++) begin
            if (bus.i_rx_ctrl[j] && (!term_found || j < term_idx)) begin
                ctrl_err = 1'b1;
            end
        end
        term_len = byte_cnt + CNT_W'(term_idx);
    end

    // Framing FSM with registered write port, handshake, abort pulse and counters.
    // The word address is derived from the last written address. o_wr_addr changes only on writes.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments, so every branch sees the pre-edge values.
        if (i_rst) begin
            state             <= S_IDLE;
            byte_cnt          <= '0;
            bus.o_wr_en       <= 1'b0;
            bus.o_wr_addr     <= '0;
            bus.o_wr_data     <= '0;
            bus.o_frame_valid <= 1'b0;
            bus.o_frame_len   <= '0;
            bus.o_abort       <= 1'b0;
            bus.o_drop_cnt    <= '0;
            bus.o_abort_cnt   <= '0;
        end else begin
            bus.o_wr_en <= 1'b0;
            bus.o_abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Stray words are ignored here, including the tail of a dropped frame.
                    if (is_start) begin
                        bus.o_wr_en   <= 1'b1;
                        bus.o_wr_addr <= '0;
                        bus.o_wr_data <= bus.i_rx_data;
                        byte_cnt      <= WORD_B;
                        state         <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (is_start) begin
                        bus.o_abort     <= 1'b1;
                        bus.o_abort_cnt <= sat_inc(bus.o_abort_cnt);
                        bus.o_wr_en     <= 1'b1;
                        bus.o_wr_addr   <= '0;
                        bus.o_wr_data   <= bus.i_rx_data;
                        byte_cnt        <= WORD_B;
                    end else if (bus.i_rx_valid) begin
                        if (ctrl_err) begin
                            bus.o_abort     <= 1'b1;
                            bus.o_abort_cnt <= sat_inc(bus.o_abort_cnt);
                            state           <= S_IDLE;
                        end else if (term_found) begin
                            bus.o_wr_en   <= 1'b1;
                            bus.o_wr_addr <= bus.o_wr_addr + ADDR_WIDTH'(1);
                            bus.o_wr_data <= bus.i_rx_data;
                            if (term_len > MAX_LEN) begin
                                bus.o_abort     <= 1'b1;
                                bus.o_abort_cnt <= sat_inc(bus.o_abort_cnt);
                                state           <= S_IDLE;
                            end else begin
                                bus.o_frame_len <= term_len[LEN_WIDTH-1:0];
                                state           <= S_HOLD;
                            end
                        end else if (byte_cnt + WORD_B > MAX_LEN) begin
                            bus.o_abort     <= 1'b1;
                            bus.o_abort_cnt <= sat_inc(bus.o_abort_cnt);
                            state           <= S_IDLE;
                        end else begin
                            bus.o_wr_en   <= 1'b1;
                            bus.o_wr_addr <= bus.o_wr_addr + ADDR_WIDTH'(1);
                            bus.o_wr_data <= bus.i_rx_data;
                            byte_cnt      <= byte_cnt + WORD_B;
                        end
                    end
                end
                S_HOLD: begin
                    // Valid rises one cycle after the TERM word's write, then waits for the handshake.
                    if (!bus.o_frame_valid) begin
                        bus.o_frame_valid <= 1'b1;
                    end else if (bus.i_check_ready) begin
                        bus.o_frame_valid <= 1'b0;
                        state             <= S_IDLE;
                    end
                    // The buffer is still owned by the checker, so a new frame is dropped.
                    if (is_start) begin
                        bus.o_drop_cnt <= sat_inc(bus.o_drop_cnt);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_rx_frame_sequencer.sv
// Self-checking bench for mac_rx_frame_sequencer. A frame-level reference model predicts
// every output cycle by cycle. Directed literal checks pin the lengths, timing and counters.
module tb_mac_rx_frame_sequencer;
    localparam int MAX_FRAME = 1518;

    logic clk = 1'b0;
    logic rst;
    logic rst_v   = 1'b1;
    logic ready_v = 1'b0;

    always #5 clk = ~clk;

    mac_rx_frame_sequencer_if bus ();

    mac_rx_frame_sequencer dut (
        .clk   (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int wr_seen  = 0;
    int last_addr = 0;
    bit model_on = 1'b0;

    // Reference model state: open_bytes < 0 means no frame is open.
    int          open_bytes = -1;
    bit          holding    = 1'b0;
    logic        m_wr_en, m_valid, m_abort;
    logic [7:0]  m_addr;
    logic [63:0] m_data;
    logic [10:0] m_len;
    logic [15:0] m_drop, m_abort_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [15:0] bump(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Computes the outputs that the next clock edge must produce, from the inputs about to be sampled.
    task automatic model_step();
        bit st;
        bit cerr;
        int term;
        int len;
        m_wr_en = 1'b0;
        m_abort = 1'b0;
        if (rst) begin
            open_bytes = -1; holding = 1'b0;
            m_valid = 1'b0; m_len = '0; m_addr = '0; m_data = '0;
            m_drop = '0; m_abort_cnt = '0;
            return;
        end
        st = bus.i_rx_valid && bus.i_rx_ctrl[0] && (bus.i_rx_data[7:0] == 8'hFB);
        term = -1;
        for (int j = 0; j < 8; j++)
            if (term < 0 && bus.i_rx_ctrl[j] && bus.i_rx_data[8*j +: 8] == 8'hFD) term = j;
        cerr = 1'b0;
        for (int j = 0; j < 8; j++)
            if (bus.i_rx_ctrl[j] && (term < 0 || j < term)) cerr = 1'b1;

        if (holding) begin
            if (st) m_drop = bump(m_drop);
            if (!m_valid) m_valid = 1'b1;
            else if (bus.i_check_ready) begin m_valid = 1'b0; holding = 1'b0; end
            return;
        end
        if (!bus.i_rx_valid) return;
        if (open_bytes < 0) begin
            if (st) begin
                m_wr_en = 1'b1; m_addr = 8'd0; m_data = bus.i_rx_data; open_bytes = 8;
            end
            return;
        end
        if (st) begin
            m_abort = 1'b1; m_abort_cnt = bump(m_abort_cnt);
            m_wr_en = 1'b1; m_addr = 8'd0; m_data = bus.i_rx_data; open_bytes = 8;
        end else if (cerr) begin
            m_abort = 1'b1; m_abort_cnt = bump(m_abort_cnt); open_bytes = -1;
        end else if (term >= 0) begin
            m_wr_en = 1'b1; m_addr = 8'(open_bytes / 8); m_data = bus.i_rx_data;
            len = open_bytes + term;
            open_bytes = -1;
            if (len > MAX_FRAME) begin
                m_abort = 1'b1; m_abort_cnt = bump(m_abort_cnt);
            end else begin
                m_len = 11'(len); holding = 1'b1;
            end
        end else if (open_bytes + 8 > MAX_FRAME) begin
            m_abort = 1'b1; m_abort_cnt = bump(m_abort_cnt); open_bytes = -1;
        end else begin
            m_wr_en = 1'b1; m_addr = 8'(open_bytes / 8); m_data = bus.i_rx_data;
            open_bytes = open_bytes + 8;
        end
    endtask

    // Compare process: 1 time unit after each rising edge, all DUT outputs against the model.
    initial forever begin
        @(posedge clk);
        #1;
        if (model_on) begin
            check("wr_en", 64'(bus.o_wr_en), 64'(m_wr_en));
            if (m_wr_en) begin
                check("wr_addr", 64'(bus.o_wr_addr), 64'(m_addr));
                check("wr_data", bus.o_wr_data, m_data);
            end
            check("frame_valid", 64'(bus.o_frame_valid), 64'(m_valid));
            check("frame_len", 64'(bus.o_frame_len), 64'(m_len));
            check("abort", 64'(bus.o_abort), 64'(m_abort));
            check("drop_cnt", 64'(bus.o_drop_cnt), 64'(m_drop));
            check("abort_cnt", 64'(bus.o_abort_cnt), 64'(m_abort_cnt));
            if (bus.o_wr_en === 1'b1) begin
                wr_seen++;
                last_addr = int'(bus.o_wr_addr);
            end
        end
    end

    // Drives one input word for the coming edge and returns at the following falling edge.
    task automatic drive(input logic [63:0] d, input logic [7:0] c, input logic v);
        bus.i_rx_data     = d;
        bus.i_rx_ctrl     = c;
        bus.i_rx_valid    = v;
        bus.i_check_ready = ready_v;
        rst               = rst_v;
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive({$urandom, $urandom}, 8'($urandom), 1'b0);
    endtask

    function automatic logic [63:0] term_data(input int lane);
        logic [63:0] d;
        for (int b = 0; b < 8; b++) begin
            if (b < lane)       d[8*b +: 8] = 8'(48 + b);
            else if (b == lane) d[8*b +: 8] = 8'hFD;
            else                d[8*b +: 8] = 8'h07;
        end
        return d;
    endfunction

    function automatic logic [7:0] term_ctrl(input int lane);
        logic [7:0] c;
        for (int b = 0; b < 8; b++) c[b] = (b >= lane);
        return c;
    endfunction

    task automatic send_start();
        drive(64'hD555_5555_5555_55FB, 8'h01, 1'b1);
    endtask

    task automatic send_data(input int n);
        for (int i = 0; i < n; i++) drive({$urandom, $urandom}, 8'h00, 1'b1);
    endtask

    task automatic send_frame(input int n_data, input int lane);
        send_start();
        send_data(n_data);
        drive(term_data(lane), term_ctrl(lane), 1'b1);
    endtask

    initial begin
        // 1: reset with random inputs
        model_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ready_v = 1'($urandom);
            drive({$urandom, $urandom}, 8'($urandom), 1'($urandom));
        end
        check("rst_wr_en", 64'(bus.o_wr_en), 64'd0);
        check("rst_valid", 64'(bus.o_frame_valid), 64'd0);
        check("rst_abort_cnt", 64'(bus.o_abort_cnt), 64'd0);
        rst_v = 1'b0;
        ready_v = 1'b1;
        idle(2);

        // 2: START + 8 data words + TERM in lane 0 of word 10 -> 72 bytes, writes at 0..9
        wr_seen = 0;
        send_frame(8, 0);
        check("t2_term_write", 64'(bus.o_wr_addr), 64'd9);
        check("t2_valid_n1", 64'(bus.o_frame_valid), 64'd0);
        idle(1);
        check("t2_valid_n2", 64'(bus.o_frame_valid), 64'd1);
        check("t2_len", 64'(bus.o_frame_len), 64'd72);
        idle(1);
        check("t2_valid_after_hs", 64'(bus.o_frame_valid), 64'd0);
        check("t2_writes", 64'(wr_seen), 64'd10);

        // 3: the same frame with TERM in lane 5 -> 77 bytes
        wr_seen = 0;
        send_frame(8, 5);
        idle(1);
        check("t3_len", 64'(bus.o_frame_len), 64'd77);
        idle(2);
        check("t3_writes", 64'(wr_seen), 64'd10);

        // 4: the checker is not ready, so a second frame is dropped and its tail ignored
        ready_v = 1'b0;
        send_frame(8, 0);
        idle(2);
        wr_seen = 0;
        send_frame(8, 3);
        check("t4_no_writes", 64'(wr_seen), 64'd0);
        check("t4_drop_cnt", 64'(bus.o_drop_cnt), 64'd1);
        check("t4_len_held", 64'(bus.o_frame_len), 64'd72);
        check("t4_valid_held", 64'(bus.o_frame_valid), 64'd1);
        send_start();
        check("t4_drop_cnt2", 64'(bus.o_drop_cnt), 64'd2);
        ready_v = 1'b1;
        idle(1);
        check("t4_valid_after_hs", 64'(bus.o_frame_valid), 64'd0);
        send_data(3);
        drive(term_data(2), term_ctrl(2), 1'b1);
        idle(2);
        check("t4_tail_ignored", 64'(wr_seen), 64'd0);

        // 5: control character in lane 3 of word 5 aborts the frame
        wr_seen = 0;
        send_start();
        send_data(3);
        drive(64'h1111_1111_0711_1111, 8'h08, 1'b1);
        check("t5_abort", 64'(bus.o_abort), 64'd1);
        check("t5_abort_cnt", 64'(bus.o_abort_cnt), 64'd1);
        idle(1);
        check("t5_abort_pulse", 64'(bus.o_abort), 64'd0);
        idle(3);
        check("t5_no_valid", 64'(bus.o_frame_valid), 64'd0);
        check("t5_writes", 64'(wr_seen), 64'd4);

        // 6a: 190 words without TERM -> abort on the 190th word, writes 0..188
        wr_seen = 0;
        send_start();
        send_data(189);
        check("t6_abort", 64'(bus.o_abort), 64'd1);
        check("t6_abort_cnt", 64'(bus.o_abort_cnt), 64'd2);
        check("t6_writes", 64'(wr_seen), 64'd189);
        check("t6_last_addr", 64'(last_addr), 64'd188);
        idle(2);

        // 6b: TERM in lane 6 of word 190 -> exactly 1518 bytes, accepted
        wr_seen = 0;
        send_frame(188, 6);
        idle(1);
        check("t6_max_valid", 64'(bus.o_frame_valid), 64'd1);
        check("t6_max_len", 64'(bus.o_frame_len), 64'd1518);
        idle(2);
        check("t6_max_writes", 64'(wr_seen), 64'd190);

        // 6c: TERM in lane 7 -> 1519 bytes, aborted
        send_frame(188, 7);
        check("t6_over_abort", 64'(bus.o_abort), 64'd1);
        check("t6_over_abort_cnt", 64'(bus.o_abort_cnt), 64'd3);
        idle(2);
        check("t6_over_no_valid", 64'(bus.o_frame_valid), 64'd0);

        // 7: a START inside an open frame aborts it and restarts at address 0
        send_start();
        send_data(2);
        send_start();
        check("t7_restart_abort", 64'(bus.o_abort), 64'd1);
        check("t7_restart_addr", 64'(bus.o_wr_addr), 64'd0);
        send_data(1);
        drive(term_data(2), term_ctrl(2), 1'b1);
        idle(1);
        check("t7_len", 64'(bus.o_frame_len), 64'd18);
        idle(2);

        // 8: reset mid-frame discards the frame without an abort pulse
        send_start();
        send_data(2);
        rst_v = 1'b1;
        idle(1);
        check("t8_no_abort", 64'(bus.o_abort), 64'd0);
        check("t8_abort_cnt_clr", 64'(bus.o_abort_cnt), 64'd0);
        check("t8_drop_cnt_clr", 64'(bus.o_drop_cnt), 64'd0);
        rst_v = 1'b0;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
